// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction bus and decode handshake bundle for fetch_ctrl
//
// Purpose: groups the instruction-bus request/response and the decode-side
//          valid/ready channel of the fetch sequencer.
// Signals:
//   ireq_valid     request pending on the instruction bus
//   ireq_addr      request address (64)
//   iresp_data_ok  response strobe for the pending request
//   iresp_data     response data (64, low 32 bits = instruction)
//   if_valid       fetched instruction available to decode
//   if_ready       decode accepts this cycle
//   if_inst        fetched instruction (32)
//   if_pc          address of if_inst (64)
// Modports: master = fetch_ctrl side, slave = bus / decode side.

interface fetch_ctrl_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [63:0] iresp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [63:0] if_pc;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_data_ok,
        input  iresp_data,
        output if_valid,
        input  if_ready,
        output if_inst,
        output if_pc
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_data_ok,
        output iresp_data,
        input  if_valid,
        output if_ready,
        input  if_inst,
        input  if_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with redirect and in-flight squash
//
// Purpose: owns the PC, issues one instruction-bus request at a time, buffers the
//          returned instruction in a 1-entry output register and hands it to decode
//          with valid/ready. Redirects from later stages replace the PC; a redirect
//          arriving while a request is in flight waits (SQUASH) for that response
//          and discards it.
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   bus             fetch_ctrl_if.master (ibus request/response, decode handshake)
//   redirect_valid  1-cycle redirect pulse
//   redirect_pc     redirect target (64)
//   busy            a bus request is outstanding (REQ or SQUASH)

module fetch_ctrl #(
    parameter logic [63:0] PC_INIT = 64'h8000_0000,
    parameter logic [63:0] PC_STEP = 64'd4
) (
    input  logic               clk,
    input  logic               rst,
    fetch_ctrl_if.master       bus,
    input  logic               redirect_valid,
    input  logic [63:0]        redirect_pc,
    output logic               busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_SQUASH = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] pend_q, pend_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [63:0] if_pc_q, if_pc_d;
    logic        ireq_valid_q, ireq_valid_d;
    logic        busy_q, busy_d;

    // Only the low word of the response carries the instruction.
    logic unused_resp_hi;
    assign unused_resp_hi = ^bus.iresp_data[63:32];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        if_valid_d = if_valid_q;
        if_inst_d  = if_inst_q;
        if_pc_d    = if_pc_q;

        case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                state_d = S_REQ;
            end
            S_REQ: begin
                if (bus.iresp_data_ok) begin
                    if (redirect_valid) begin
                        // Redirect wins over the arriving data.
                        pc_d    = redirect_pc;
                        state_d = S_IDLE;
                    end else begin
                        if_inst_d  = bus.iresp_data[31:0];
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + PC_STEP;
                        state_d    = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    // Request cannot be withdrawn: remember the target, wait for data.
                    pend_d  = redirect_pc;
                    state_d = S_SQUASH;
                end
            end
            S_SQUASH: begin
                if (redirect_valid) begin
                    pend_d = redirect_pc;
                end
                if (bus.iresp_data_ok) begin
                    pc_d    = redirect_valid ? redirect_pc : pend_q;
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    pc_d       = redirect_pc;
                    state_d    = S_IDLE;
                end else if (bus.if_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered request/busy flags follow the next state so they line up with it.
        ireq_valid_d = (state_d == S_REQ) || (state_d == S_SQUASH);
        busy_d       = ireq_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= PC_INIT;
            pend_q       <= 64'd0;
            if_valid_q   <= 1'b0;
            if_inst_q    <= 32'd0;
            if_pc_q      <= 64'd0;
            ireq_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            if_valid_q   <= if_valid_d;
            if_inst_q    <= if_inst_d;
            if_pc_q      <= if_pc_d;
            ireq_valid_q <= ireq_valid_d;
            busy_q       <= busy_d;
        end
    end

    // pc only changes outside REQ/SQUASH, so it doubles as the stable request address.
    assign bus.ireq_valid = ireq_valid_q;
    assign bus.ireq_addr  = pc_q;
    assign bus.if_valid   = if_valid_q;
    assign bus.if_inst    = if_inst_q;
    assign bus.if_pc      = if_pc_q;
    assign busy           = busy_q;

endmodule
